// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction fetch slice.
//   ADDR_W        : instruction memory word-address width
//   INSTR_W       : instruction width
//   fetch_entry_t : one prefetch buffer entry {pc, instr}
//   fetch_state_e : fetch sequencer states
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int ADDR_W  = 5;
   localparam int INSTR_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Synchronous FIFO of fetch_entry_t with flush. Flush wins over push and pop.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push         : enqueue push_entry (ignored when full unless popping)
//   push_entry   : entry to enqueue
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all contents, pointers back to zero
//   full, empty  : occupancy flags
//   count        : number of valid entries (0..DEPTH)
//   head         : oldest entry, read straight from storage
// -----------------------------------------------------------------------------
module fetch_buf
   import imem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  fetch_entry_t           push_entry,
   input  logic                   pop,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == CNT_W'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A full buffer still accepts a push when the head leaves the same cycle.
   assign do_push = push & (~full | do_pop);

   // NOTE: storage is reset because head feeds decode-visible outputs, which
   // must read as zero out of reset; this is cheap at this depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction fetch sequencer in front of a combinational-read instruction
// memory. Owns the fetch PC, prefetches into a small buffer and hands
// {pc, instr} to decode over valid/ready. Redirects flush and re-steer.
//
// Optional feature: define IMEM_FETCH_HALT_DETECT_EN to stop fetching after a
// HALT_OPCODE word is pushed (halted=1 until the next redirect). Without it
// HALT is unreachable and halted is tied 0.
//
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   en              : fetch enable (0 pauses fetch, buffer kept and drains)
//   imem_addr       : memory word address (the fetch_pc register)
//   imem_instr      : memory read data for imem_addr, same cycle
//   redirect_valid  : one-cycle flush + re-steer request
//   redirect_pc     : new fetch PC
//   out_valid/ready : decode handshake
//   out_instr/out_pc: head instruction and its fetch address
//   halted          : fetch stopped on halt opcode
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int                 DEPTH       = 2,
   parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
   parameter logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               halted
);

   fetch_state_e          state_q;
   fetch_state_e          state_d;
   logic [ADDR_W-1:0]     fetch_pc_q;
   logic [ADDR_W-1:0]     fetch_pc_d;
   fetch_entry_t          last_head_q;
   fetch_entry_t          head;
   fetch_entry_t          push_entry;
   logic                  buf_full;
   logic                  buf_empty;
   logic [$clog2(DEPTH):0] buf_count_unused;
   logic                  push;
   logic                  pop;
   logic                  is_halt_word;

`ifdef IMEM_FETCH_HALT_DETECT_EN
   assign is_halt_word = (imem_instr == HALT_OPCODE);
   assign halted       = (state_q == HALT);
`else
   logic halt_opcode_unused;
   assign halt_opcode_unused = ^HALT_OPCODE;
   assign is_halt_word       = 1'b0;
   assign halted             = 1'b0;
`endif

   assign imem_addr  = fetch_pc_q;
   assign out_valid  = ~buf_empty;
   assign pop        = out_valid & out_ready;
   assign push       = (state_q == RUN) & en & (~buf_full | pop);
   assign push_entry = '{pc: fetch_pc_q, instr: imem_instr};

   // When empty, the outputs keep showing the last head seen rather than
   // whatever stale word sits in the next storage slot.
   assign out_instr = buf_empty ? last_head_q.instr : head.instr;
   assign out_pc    = buf_empty ? last_head_q.pc    : head.pc;

   fetch_buf #(
      .DEPTH (DEPTH)
   ) u_fetch_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .full       (buf_full),
      .empty      (buf_empty),
      .count      (buf_count_unused),
      .head       (head)
   );

   // NOTE: every output of this block gets a default first, so no path
   // through the case/if tree can leave a value unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;

      if (redirect_valid) begin
         // Redirect beats push, pop and halt in the same cycle.
         fetch_pc_d = redirect_pc;
         state_d    = en ? RUN : IDLE;
      end else begin
         // A halt word is enqueued but the PC stays on its address.
         if (push && !is_halt_word) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
         end
         case (state_q)
            IDLE: if (en) state_d = RUN;
            RUN: begin
               if (!en)                       state_d = IDLE;
               else if (push && is_halt_word) state_d = HALT;
            end
            HALT: if (!en) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         last_head_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         if (!buf_empty) begin
            last_head_q <= head;
         end
      end
   end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction fetch sequencer in front of the 32x16 instruction memory (combinational read, 5-bit word address).
- Owns the fetch PC and drives the memory address each cycle.
- Captures returned words into a small prefetch buffer.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Accepts branch/jump redirects that flush the buffer and re-steer fetch.

Parameters:
ADDR_W, 5, instruction memory word-address width.
INSTR_W, 16, instruction width.
DEPTH, 2, prefetch buffer entries (power of two, >=2).
RESET_PC, 0, fetch PC after reset.
HALT_OPCODE, 16'hFFFF, instruction word treated as halt (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
en  in  1  fetch enable; 0 pauses fetching, buffer contents kept.
imem_addr  out  ADDR_W  word address to instruction memory; always equals fetch_pc.
imem_instr  in  INSTR_W  instruction word from memory, valid same cycle as imem_addr.
redirect_valid  in  1  single-cycle pulse: flush and re-steer.
redirect_pc  in  ADDR_W  new fetch PC, sampled when redirect_valid=1.
out_valid  out  1  buffer head valid.
out_ready  in  1  decode accepts head.
out_instr  out  INSTR_W  head instruction.
out_pc  out  ADDR_W  address the head instruction was fetched from.
halted  out  1  fetch stopped on halt opcode (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC, buffer empty, state=IDLE.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - imem_addr=RESET_PC.
- States: IDLE, RUN, HALT.
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0.
  - RUN->HALT per Optional Feature.
  - HALT->RUN on redirect_valid (en=1) or ->IDLE (en=0).
  - Redirect from any state updates fetch_pc.
- pop = out_valid & out_ready.
- push = (state==RUN) & en & (count<DEPTH | pop).
- On push, at the clock edge:
  - enqueue {fetch_pc, imem_instr};
  - fetch_pc <= fetch_pc+1, modulo 2^ADDR_W (31 wraps to 0).
- Push and pop in the same cycle are both performed; count is unchanged.
- Latency and throughput:
  - Word at address A is visible on out_* one cycle after imem_addr=A is pushed.
  - Sustained throughput is 1 instr/cycle with out_ready held 1.
- Full buffer with out_ready=0: fetch_pc holds; imem_addr is stable; no push.
- Empty buffer: out_valid=0; out_instr/out_pc hold their last value (don't-care to decode).
- redirect_valid=1 has priority over everything that cycle:
  - buffer flushed (count=0) and any push or pop that cycle is discarded;
  - fetch_pc <= redirect_pc and halted <= 0;
  - out_valid=0 the next cycle;
  - the first redirected instruction appears 2 cycles after the redirect pulse if en=1 and state resolves to RUN.
- en deasserted mid-stream: pushes stop at the next edge; the buffer still drains to decode.
- Asynchronous reset mid-operation: immediate return to reset values; buffer contents lost.
- Outputs out_* are registered from buffer storage; imem_addr is fetch_pc register (no combinational path from any input).

Optional Feature:
Macro IMEM_FETCH_HALT_DETECT_EN.
- Defined:
  - A push whose imem_instr==HALT_OPCODE enqueues that word normally.
  - State then goes to HALT, halted=1 from the next cycle, and fetch_pc stops incrementing (holds at halt address).
  - No further pushes until a redirect.
  - The buffer drains normally.
- Not defined:
  - HALT state is unreachable; HALT_OPCODE is an ordinary instruction.
  - halted is tied 0 and fetch wraps continuously.

Decomposition:
Package imem_pkg holds:
- ADDR_W and INSTR_W constants;
- typedef fetch_entry_t (packed struct {pc, instr});
- enum fetch_state_e {IDLE, RUN, HALT}.

One sub-module, fetch_buf: a synchronous FIFO of fetch_entry_t with flush.
- Ports: push, pop, flush, full, empty, count, head.
- Flush has priority over push and pop.

Test Plan:
- Reset release, en=1, out_ready=1, memory 0..4 = 16'h1000..16'h1004 -> out_valid first high cycle 2 after en, then pc 0,1,2,3,4 with those instructions on consecutive cycles.
- out_ready=0 for 5 cycles after the first instruction -> count saturates at 2, imem_addr frozen at 2, no loss or duplication when ready returns (pcs 0,1,2,... in order).
- Redirect to pc=20 while the buffer holds pcs 3,4 and out_ready=1 -> pcs 3,4 never accepted after the pulse, out_valid=0 next cycle, next output pc=20.
- Free-run from pc=30 -> output pcs 30,31,0,1, wrap without gap.
- With IMEM_FETCH_HALT_DETECT_EN, word 5 = 16'hFFFF -> pcs 0..5 delivered, halted=1, imem_addr stays 5, no pc 6 until redirect to 0 clears halted.
- rst_n pulled low asynchronously mid-stream, between clock edges -> out_valid=0 and imem_addr=0 immediately; restart delivers from pc 0.
